// File: rtl/dram_rrarb_pkg.sv
// Shared helpers for the port-1 round-robin arbiter and its picker.
package dram_rrarb_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/dram_rrarb_rr_pick.sv
// Combinational round-robin picker: lowest eligible index at or after ptr, with wrap.
module rr_pick
    import dram_rrarb_pkg::*;
#(
    parameter int NM = 4,
    localparam int PW = clog2(NM)
)(
    input  logic [NM-1:0] elig,
    input  logic [PW-1:0] ptr,
    output logic [NM-1:0] gnt,
    output logic [PW-1:0] idx
);

    localparam logic [PW:0] NM_W = (PW+1)'(NM);

    logic [2*NM-1:0] dbl;
    logic [NM-1:0]   rot;
    logic [PW-1:0]   off;
    logic [PW:0]     sum;
    logic            found;

    // Rotating the doubled vector puts requester ptr at bit 0.
    assign dbl = {elig, elig} >> ptr;
    assign rot = dbl[NM-1:0];

    always_comb begin
        off   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NM; i++) begin
            if (!found && rot[i]) begin
                off   = PW'(i);
                found = 1'b1;
            end
        end
    end

    assign sum = {1'b0, ptr} + {1'b0, off};
    assign idx = (sum >= NM_W) ? PW'(sum - NM_W) : sum[PW-1:0];
    assign gnt = found ? (NM'(1) << idx) : '0;

endmodule

// File: rtl/dram_rrarb.sv
// Round-robin arbiter sharing RAM port 1 among NM requesters; one access per cycle,
// registered read data returned with a one-cycle ack pulse.
module dram_rrarb
    import dram_rrarb_pkg::*;
#(
    parameter int NM = 4,
    parameter int SZ = 256,
    parameter int DW = 32,
    localparam int AW = clog2(SZ)
)(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NM-1:0]    req_i,
    input  logic [NM-1:0]    we_i,
    input  logic [NM*AW-1:0] addr_i,
    input  logic [NM*DW-1:0] data_i,
    output logic [NM-1:0]    ack_o,
    output logic [DW-1:0]    data_o,
    output logic [NM-1:0]    gnt_o,
    output logic             ram_we_o,
    output logic [AW-1:0]    ram_addr_o,
    output logic [DW-1:0]    ram_data_o,
    input  logic [DW-1:0]    ram_q_i
);

    localparam int PW = clog2(NM);

    logic [NM-1:0] elig;
    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic          any;

    // A requester in its ack cycle is masked so its held request is not served twice.
    assign elig = req_i & ~ack_o;

    rr_pick #(.NM(NM)) u_pick (
        .elig (elig),
        .ptr  (ptr),
        .gnt  (gnt_o),
        .idx  (gidx)
    );

    assign any = |gnt_o;

    always_comb begin
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_data_o = '0;
        if (any) begin
            ram_we_o   = we_i[gidx] & ~rst_i;
            ram_addr_o = addr_i[int'(gidx)*AW +: AW];
            ram_data_o = data_i[int'(gidx)*DW +: DW];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr    <= '0;
            ack_o  <= '0;
            data_o <= '0;
        end else if (any) begin
            ack_o  <= gnt_o;
            data_o <= ram_q_i;
            ptr    <= (gidx == PW'(NM-1)) ? '0 : gidx + 1'b1;
        end else begin
            ack_o <= '0;
        end
    end

endmodule

// File: tb/tb_dram_rrarb.sv
// Bench for dram_rrarb: RAM model, rule-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_dram_rrarb;

    localparam int NM = 4;
    localparam int SZ = 256;
    localparam int DW = 32;
    localparam int AW = 8;

    logic             clk = 1'b0;
    logic             rst_i;
    logic [NM-1:0]    req_i;
    logic [NM-1:0]    we_i;
    logic [NM*AW-1:0] addr_i;
    logic [NM*DW-1:0] data_i;
    logic [NM-1:0]    ack_o;
    logic [DW-1:0]    data_o;
    logic [NM-1:0]    gnt_o;
    logic             ram_we_o;
    logic [AW-1:0]    ram_addr_o;
    logic [DW-1:0]    ram_data_o;
    logic [DW-1:0]    ram_q_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dram_rrarb #(.NM(NM), .SZ(SZ), .DW(DW)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .ack_o      (ack_o),
        .data_o     (data_o),
        .gnt_o      (gnt_o),
        .ram_we_o   (ram_we_o),
        .ram_addr_o (ram_addr_o),
        .ram_data_o (ram_data_o),
        .ram_q_i    (ram_q_i)
    );

    // Environment RAM port 1: asynchronous read, write at the edge.
    logic [DW-1:0] mem [0:SZ-1];
    assign ram_q_i = mem[ram_addr_o];
    always @(posedge clk) if (ram_we_o) mem[ram_addr_o] <= ram_data_o;

    // Reference model: last granted requester, expected ack/data, shadow memory.
    int            last_g = NM-1;
    logic [NM-1:0] m_ack  = '0;
    logic [DW-1:0] m_data = '0;
    logic [DW-1:0] shadow [0:SZ-1];

    initial begin
        for (int i = 0; i < SZ; i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end
        mem[1] = 32'hA; shadow[1] = 32'hA;
        mem[2] = 32'hB; shadow[2] = 32'hB;
        mem[3] = 32'hC; shadow[3] = 32'hC;
    end

    function automatic int pick(input logic [NM-1:0] req, input logic [NM-1:0] ack, input int last);
        for (int k = 1; k <= NM; k++) begin
            automatic int m = (last + k) % NM;
            if (req[m] && !ack[m]) return m;
        end
        return -1;
    endfunction

    function automatic int cur_pick();
        return pick(req_i, m_ack, last_g);
    endfunction

    function automatic logic [AW-1:0] addr_of(input int m);
        return addr_i[m*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] wdata_of(input int m);
        return data_i[m*DW +: DW];
    endfunction

    function automatic logic [NM-1:0] exp_gnt();
        automatic int g = cur_pick();
        if (g < 0) return '0;
        return NM'(1 << g);
    endfunction

    function automatic logic exp_we();
        automatic int g = cur_pick();
        if (g < 0) return 1'b0;
        return we_i[g] & ~rst_i;
    endfunction

    function automatic logic [AW-1:0] exp_addr();
        automatic int g = cur_pick();
        if (g < 0) return '0;
        return addr_of(g);
    endfunction

    function automatic logic [DW-1:0] exp_wdata();
        automatic int g = cur_pick();
        if (g < 0) return '0;
        return wdata_of(g);
    endfunction

    always @(posedge clk) begin
        if (rst_i) begin
            last_g <= NM-1;
            m_ack  <= '0;
            m_data <= '0;
        end else if (cur_pick() >= 0) begin
            m_ack  <= NM'(1 << cur_pick());
            m_data <= shadow[addr_of(cur_pick())];
            if (we_i[cur_pick()]) shadow[addr_of(cur_pick())] <= wdata_of(cur_pick());
            last_g <= cur_pick();
        end else begin
            m_ack <= '0;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("gnt",      32'(gnt_o),      32'(exp_gnt()));
        chk("ram_we",   32'(ram_we_o),   32'(exp_we()));
        chk("ram_addr", 32'(ram_addr_o), 32'(exp_addr()));
        chk("ram_data", ram_data_o,      exp_wdata());
        chk("ack",      32'(ack_o),      32'(m_ack));
        chk("data_o",   data_o,          m_data);
    end

    task automatic set_port(input int m, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we_i[m]             = w;
        addr_i[m*AW +: AW]  = a;
        data_i[m*DW +: DW]  = d;
        req_i[m]            = 1'b1;
    endtask

    // Called just after a posedge; returns edges waited until ack and the data seen then.
    task automatic do_access(input int m, input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, output logic [DW-1:0] rd, output int waits);
        set_port(m, w, a, d);
        waits = 0;
        rd    = '0;
        for (int n = 1; n <= 32; n++) begin
            @(posedge clk); #1;
            if (ack_o[m]) begin
                waits = n;
                rd    = data_o;
                break;
            end
        end
        req_i[m] = 1'b0;
        chk("ack_seen", 32'(waits != 0), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rd;
        int            w;

        rst_i  = 1'b1;
        req_i  = 4'b1111;
        we_i   = 4'b1111;
        addr_i = {4{8'h07}};
        data_i = {4{32'h99}};
        repeat (2) begin
            @(negedge clk);
            chk("reset_ack",  32'(ack_o),    32'd0);
            chk("reset_we",   32'(ram_we_o), 32'd0);
            chk("reset_data", data_o,        32'd0);
        end

        // Full contention: all requests held, strict rotation expected.
        @(posedge clk); #1;
        rst_i  = 1'b0;
        we_i   = '0;
        addr_i = {8'h04, 8'h03, 8'h02, 8'h01};
        data_i = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rot_gnt", 32'(gnt_o), 32'(1 << (k % 4)));
            if (k > 0) chk("rot_ack", 32'(ack_o), 32'(1 << ((k - 1) % 4)));
            else       chk("rot_ack0", 32'(ack_o), 32'd0);
            @(posedge clk); #1;
        end
        req_i = '0;
        @(posedge clk); #1;

        do_access(3, 1'b0, 8'h03, '0, rd, w);
        chk("m3_alone_wait", 32'(w), 32'd1);
        chk("m3_alone_data", rd, 32'hC);

        do_access(2, 1'b1, 8'h10, 32'hDEADBEEF, rd, w);
        chk("m2_wr_wait", 32'(w), 32'd1);
        do_access(2, 1'b0, 8'h10, '0, rd, w);
        chk("m2_rd_wait", 32'(w), 32'd2);
        chk("m2_rd_data", rd, 32'hDEADBEEF);

        // Last grant was m2, so m0 must win before m1.
        set_port(0, 1'b0, 8'h01, '0);
        set_port(1, 1'b0, 8'h02, '0);
        @(negedge clk);
        chk("wrap_g0", 32'(gnt_o), 32'b0001);
        @(posedge clk); #1;
        chk("wrap_a0", 32'(ack_o), 32'b0001);
        chk("wrap_d0", data_o, 32'hA);
        req_i[0] = 1'b0;
        @(negedge clk);
        chk("wrap_g1", 32'(gnt_o), 32'b0010);
        @(posedge clk); #1;
        chk("wrap_a1", 32'(ack_o), 32'b0010);
        chk("wrap_d1", data_o, 32'hB);
        req_i[1] = 1'b0;
        @(posedge clk); #1;

        do_access(1, 1'b0, 8'h01, '0, rd, w);
        chk("stream1_wait", 32'(w), 32'd1);
        chk("stream1_data", rd, 32'hA);
        do_access(1, 1'b0, 8'h02, '0, rd, w);
        chk("stream2_wait", 32'(w), 32'd2);
        chk("stream2_data", rd, 32'hB);
        do_access(1, 1'b0, 8'h03, '0, rd, w);
        chk("stream3_wait", 32'(w), 32'd2);
        chk("stream3_data", rd, 32'hC);

        // Write granted while reset is high must not land.
        set_port(0, 1'b1, 8'h05, 32'h55);
        rst_i = 1'b1;
        @(negedge clk);
        chk("rst_mid_gnt", 32'(gnt_o),    32'b0001);
        chk("rst_mid_we",  32'(ram_we_o), 32'd0);
        @(posedge clk); #1;
        chk("rst_mid_ack", 32'(ack_o), 32'd0);
        rst_i    = 1'b0;
        req_i[0] = 1'b0;
        we_i[0]  = 1'b0;
        @(posedge clk); #1;
        do_access(0, 1'b0, 8'h05, '0, rd, w);
        chk("rst_mid_rd_wait", 32'(w), 32'd1);
        chk("rst_mid_rd_data", rd, 32'd0);

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
